// File: rtl/arbitro_memoria_dados.sv
// Sequencer/arbiter for the shared data memory: port 0 = MEM stage, port 1 = loader/debug master.
// Build option: define ARB_FIXED_PRIORITY_EN to make port 0 win every tie (no round-robin pointer).
module arbitro_memoria_dados #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall0
);

  localparam int unsigned LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              owner, owner_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              gnt0_nx, gnt1_nx, done0_nx, done1_nx;
  logic              mem_read_nx, mem_write_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, rdata0_nx, rdata1_nx;
  logic              win_valid_c, win_c, sel_we_c;
`ifndef ARB_FIXED_PRIORITY_EN
  logic              prio1, prio1_nx;
`endif

  // Winner select: win_c = 1 means port 1
  always_comb begin
    win_valid_c = req0 | req1;
`ifdef ARB_FIXED_PRIORITY_EN
    win_c = ~req0;
`else
    win_c = (req0 & req1) ? prio1 : req1;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    cnt_nx       = cnt;
    gnt0_nx      = 1'b0;
    gnt1_nx      = 1'b0;
    done0_nx     = 1'b0;
    done1_nx     = 1'b0;
    mem_read_nx  = mem_read;
    mem_write_nx = mem_write;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    rdata0_nx    = rdata0;
    rdata1_nx    = rdata1;
    sel_we_c     = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    prio1_nx     = prio1;
`endif
    case (state)
      IDLE, DONE: begin
        if (win_valid_c) begin
          sel_we_c     = win_c ? we1 : we0;
          gnt0_nx      = ~win_c;
          gnt1_nx      = win_c;
          owner_nx     = win_c;
          mem_addr_nx  = win_c ? addr1 : addr0;
          mem_wdata_nx = win_c ? wdata1 : wdata0;
          mem_read_nx  = ~sel_we_c;
          mem_write_nx = sel_we_c;
          cnt_nx       = '0;
          state_nx     = ACCESS;
`ifndef ARB_FIXED_PRIORITY_EN
          prio1_nx     = ~win_c;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          if (mem_read) begin
            if (owner) rdata1_nx = mem_rdata;
            else       rdata0_nx = mem_rdata;
          end
          mem_read_nx  = 1'b0;
          mem_write_nx = 1'b0;
          done0_nx     = ~owner;
          done1_nx     = owner;
          cnt_nx       = '0;
          state_nx     = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      prio1     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      cnt       <= cnt_nx;
      gnt0      <= gnt0_nx;
      gnt1      <= gnt1_nx;
      done0     <= done0_nx;
      done1     <= done1_nx;
      mem_read  <= mem_read_nx;
      mem_write <= mem_write_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      rdata0    <= rdata0_nx;
      rdata1    <= rdata1_nx;
`ifndef ARB_FIXED_PRIORITY_EN
      prio1     <= prio1_nx;
`endif
    end
  end

  // Pipeline stall: waiting for a grant, or own access still in flight
  assign stall0 = reset_n & ((req0 & ~gnt0) | (~owner & (state == ACCESS)));

endmodule
